// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding, the latched
// request record and a byte-lane mask expander.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_resp_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic [31:0] lane_expand(input logic [3:0] mask);
        logic [31:0] bits;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/dmem_resp_array.sv
// Byte-lane word array backing the responder: one synchronous port with
// per-lane write enables and a registered read (old data on same-edge write).
module dmem_resp_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [3:0][7:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [31:0]     rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[idx_i];
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[idx_i][i] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency responder for the pipeline data-memory port. Optional
// protocol checking (proto_err port plus assertion) under DMEM_RESP_ERR_EN.
module dmem_responder
    import rv32i_types::*;
#(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp
`ifdef DMEM_RESP_ERR_EN
    ,
    output logic        proto_err
`endif
);

    dmem_resp_state_t state_q;
    logic [3:0]       lat_cnt_q;
    dmem_req_t        req_q;

    dmem_req_t   live_req;
    dmem_req_t   acc_req;
    logic        req_valid;
    logic        accept;
    logic        commit;
    logic [31:0] rd_word;
    logic [3:0]  rsel;
    logic        unused_bits;

    // With LATENCY=1 the array is accessed on the accepting edge itself, so it
    // must see the live request rather than the (not yet loaded) latch.
    always_comb begin
        live_req.addr  = dmem_addr;
        live_req.rmask = dmem_rmask;
        live_req.wmask = dmem_wmask;
        live_req.wdata = dmem_wdata;
        req_valid      = |(dmem_rmask | dmem_wmask);
        accept         = !rst && req_valid && (state_q == IDLE || state_q == RESP);
        if (LATENCY == 1) begin
            acc_req = live_req;
            commit  = accept;
        end else begin
            acc_req = req_q;
            commit  = !rst && (state_q == WAIT) && (lat_cnt_q <= 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= 4'd0;
            req_q     <= '0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        req_q <= live_req;
                        if (LATENCY == 1) begin
                            state_q   <= RESP;
                            lat_cnt_q <= 4'd0;
                        end else begin
                            state_q   <= WAIT;
                            lat_cnt_q <= 4'(LATENCY - 1);
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (lat_cnt_q <= 4'd1) begin
                        state_q   <= RESP;
                        lat_cnt_q <= 4'd0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dmem_resp_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .en_i    (commit),
        .we_i    (commit ? acc_req.wmask : 4'b0000),
        .idx_i   (acc_req.addr[DEPTH_LOG2+1:2]),
        .wdata_i (acc_req.wdata),
        .rdata_o (rd_word)
    );

    // A request carrying both masks is write-wins: its read lanes return zero.
    assign rsel        = (req_q.wmask != 4'b0000) ? 4'b0000 : req_q.rmask;
    assign dmem_resp   = (state_q == RESP);
    assign dmem_rdata  = dmem_resp ? (rd_word & lane_expand(rsel)) : 32'h0;
    assign unused_bits = ^{dmem_addr, req_q.addr, req_q.wdata};

`ifdef DMEM_RESP_ERR_EN
    logic violation;
    logic err_q;

    assign violation = !rst && req_valid &&
                       ((state_q == WAIT) || (accept && |dmem_rmask && |dmem_wmask));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (violation) begin
            err_q <= 1'b1;
        end
    end

    assign proto_err = err_q;

    assert property (@(posedge clk) !violation);
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one LATENCY=2 and one LATENCY=1 instance,
// expected responses queued with their due cycle and checked on the falling edge.
module tb_dmem_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addrA = '0, wdataA = '0, addrB = '0, wdataB = '0;
    logic [3:0]  rmaskA = '0, wmaskA = '0, rmaskB = '0, wmaskB = '0;
    logic [31:0] rdataA, rdataB;
    logic        respA, respB;
`ifdef DMEM_RESP_ERR_EN
    logic        errA, errB;
`endif

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        qA[$];
    exp_t        qB[$];
    logic [31:0] memA [0:1023];
    logic [31:0] memB [0:1023];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.LATENCY(LAT_A), .DEPTH_LOG2(10)) dutA (
        .clk(clk), .rst(rst),
        .dmem_addr(addrA), .dmem_rmask(rmaskA), .dmem_wmask(wmaskA), .dmem_wdata(wdataA),
        .dmem_rdata(rdataA), .dmem_resp(respA)
`ifdef DMEM_RESP_ERR_EN
        , .proto_err(errA)
`endif
    );

    dmem_responder #(.LATENCY(LAT_B), .DEPTH_LOG2(10)) dutB (
        .clk(clk), .rst(rst),
        .dmem_addr(addrB), .dmem_rmask(rmaskB), .dmem_wmask(wmaskB), .dmem_wdata(wdataB),
        .dmem_rdata(rdataB), .dmem_resp(respB)
`ifdef DMEM_RESP_ERR_EN
        , .proto_err(errB)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drives one request for a cycle; accepted requests update the byte model
    // and queue the response due LATENCY cycles later.
    task automatic applyStimulus(input int inst, input logic [31:0] addr, input logic [3:0] rm,
                                 input logic [3:0] wm, input logic [31:0] wd, input bit accepted);
        logic [31:0] word;
        logic [31:0] expData;
        int          idx;
        exp_t        e;
        idx     = int'(addr[11:2]);
        word    = (inst == 0) ? memA[idx] : memB[idx];
        expData = '0;
        for (int i = 0; i < 4; i++) begin
            if (rm[i] && wm == 4'b0000) expData[8*i +: 8] = word[8*i +: 8];
            if (wm[i]) word[8*i +: 8] = wd[8*i +: 8];
        end
        if (inst == 0) begin
            addrA = addr; rmaskA = rm; wmaskA = wm; wdataA = wd;
        end else begin
            addrB = addr; rmaskB = rm; wmaskB = wm; wdataB = wd;
        end
        if (accepted) begin
            e.data = expData;
            if (inst == 0) begin
                e.cyc = cyc + LAT_A;
                memA[idx] = word;
                qA.push_back(e);
            end else begin
                e.cyc = cyc + LAT_B;
                memB[idx] = word;
                qB.push_back(e);
            end
        end
        @(negedge clk);
        if (inst == 0) begin
            addrA = '0; rmaskA = '0; wmaskA = '0; wdataA = '0;
        end else begin
            addrB = '0; rmaskB = '0; wmaskB = '0; wdataB = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic monitorPort(input string name, ref exp_t q[$], input logic resp, input logic [31:0] rdata);
        exp_t e;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checkOutput({name, " missing resp"}, cyc, e.cyc);
        end
        if (resp) begin
            if (q.size() == 0) begin
                checkOutput({name, " spurious resp"}, 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                checkOutput({name, " resp cycle"}, cyc, e.cyc);
                checkOutput({name, " rdata"}, rdata, e.data);
            end
        end else begin
            checkOutput({name, " idle rdata"}, rdata, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        monitorPort("A", qA, respA, rdataA);
        monitorPort("B", qB, respB, rdataB);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: bench did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset respA", {31'b0, respA}, 32'd0);
        checkOutput("reset rdataA", rdataA, 32'h0);
        checkOutput("reset respB", {31'b0, respB}, 32'd0);
        checkOutput("reset rdataB", rdataB, 32'h0);
`ifdef DMEM_RESP_ERR_EN
        checkOutput("reset errA", {31'b0, errA}, 32'd0);
        checkOutput("reset errB", {31'b0, errB}, 32'd0);
`endif
        rst = 1'b0;
        idle(1);

        // Store then load, masked byte store and lane-masked load.
        applyStimulus(0, 32'h100, 4'b0000, 4'b1111, 32'hDEADBEEF, 1); idle(2);
        applyStimulus(0, 32'h100, 4'b1111, 4'b0000, 32'h0, 1);        idle(2);
        applyStimulus(0, 32'h100, 4'b0000, 4'b1111, 32'h11223344, 1); idle(2);
        applyStimulus(0, 32'h102, 4'b0000, 4'b0100, 32'h00AA0000, 1); idle(2);
        applyStimulus(0, 32'h100, 4'b1111, 4'b0000, 32'h0, 1);        idle(2);
        applyStimulus(0, 32'h100, 4'b0100, 4'b0000, 32'h0, 1);        idle(2);

        // Back-to-back: second request lands in WAIT and is dropped, third in RESP.
        applyStimulus(0, 32'h100, 4'b1111, 4'b0000, 32'h0, 1);
        applyStimulus(0, 32'h100, 4'b0000, 4'b1111, 32'h00000BAD, 0);
        applyStimulus(0, 32'h100, 4'b1111, 4'b0000, 32'h0, 1);
        idle(3);
`ifdef DMEM_RESP_ERR_EN
        checkOutput("errA after WAIT request", {31'b0, errA}, 32'd1);
`endif

        // Address wrap-around beyond the array depth.
        applyStimulus(0, 32'h1000, 4'b0000, 4'b1111, 32'h00000005, 1); idle(2);
        applyStimulus(0, 32'h0, 4'b1111, 4'b0000, 32'h0, 1);           idle(2);

        // Reset mid-operation drops the pending store and the reset-cycle request.
        applyStimulus(0, 32'h40, 4'b0000, 4'b1111, 32'h0, 1); idle(2);
        applyStimulus(0, 32'h44, 4'b0000, 4'b1111, 32'h0, 1); idle(2);
        applyStimulus(0, 32'h40, 4'b0000, 4'b1111, 32'h00000077, 0);
        rst = 1'b1;
        applyStimulus(0, 32'h44, 4'b0000, 4'b1111, 32'h00000099, 0);
        rst = 1'b0;
        idle(3);
        applyStimulus(0, 32'h40, 4'b1111, 4'b0000, 32'h0, 1); idle(2);
        applyStimulus(0, 32'h44, 4'b1111, 4'b0000, 32'h0, 1); idle(2);

        // LATENCY=1: back-to-back service, write-wins on both masks, read-after-write.
        applyStimulus(1, 32'h20, 4'b0000, 4'b1111, 32'h0, 1);
        applyStimulus(1, 32'h20, 4'b1111, 4'b0001, 32'h000000AB, 1);
        applyStimulus(1, 32'h20, 4'b1111, 4'b0000, 32'h0, 1);
        applyStimulus(1, 32'h24, 4'b0000, 4'b1111, 32'h12345678, 1);
        applyStimulus(1, 32'h24, 4'b1111, 4'b0000, 32'h0, 1);
        applyStimulus(1, 32'h24, 4'b0011, 4'b0000, 32'h0, 1);
        idle(4);
`ifdef DMEM_RESP_ERR_EN
        checkOutput("errB after dual mask", {31'b0, errB}, 32'd1);
`endif

        checkOutput("A queue drained", qA.size(), 32'd0);
        checkOutput("B queue drained", qB.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
